// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops words from a FIFO read port and serialises them LSB first.
// Frame: start, DATA_WIDTH data bits, optional parity, stop; one bit per CLK; TX_OUT registered.
module fifo_uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] RD_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  R_INC,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] shreg, shreg_nxt;
  logic [CW-1:0]         cnt, cnt_nxt;
  logic                  par_en_q, par_en_nxt;
  logic                  par_typ_q, par_typ_nxt;
  logic                  par_q, par_nxt;
  logic                  tx_nxt;
  logic                  load;

  // RST gating keeps the pop strobe quiet while the block is held in reset
  assign load  = RST && ((state == IDLE) || (state == STOP)) && !EMPTY;
  assign R_INC = load;
  assign BUSY  = (state != IDLE);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
      par_q     <= 1'b0;
      TX_OUT    <= 1'b1;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      par_en_q  <= par_en_nxt;
      par_typ_q <= par_typ_nxt;
      par_q     <= par_nxt;
      TX_OUT    <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    cnt_nxt     = cnt;
    par_en_nxt  = par_en_q;
    par_typ_nxt = par_typ_q;
    par_nxt     = par_q;
    tx_nxt      = 1'b1;
    if (load) begin
      // word parity is taken now because the shift register is consumed bit by bit
      state_nxt   = START;
      shreg_nxt   = RD_DATA;
      cnt_nxt     = '0;
      par_en_nxt  = PAR_EN;
      par_typ_nxt = PAR_TYP;
      par_nxt     = ^RD_DATA;
      tx_nxt      = 1'b0;
    end else begin
      case (state)
        START: begin
          state_nxt = DATA;
          tx_nxt    = shreg[0];
          shreg_nxt = shreg >> 1;
          cnt_nxt   = CW'(1);
        end
        DATA: begin
          if (cnt == LAST_BIT) begin
            if (par_en_q) begin
              state_nxt = PARITY;
              tx_nxt    = par_q ^ par_typ_q;
            end else begin
              state_nxt = STOP;
            end
          end else begin
            tx_nxt    = shreg[0];
            shreg_nxt = shreg >> 1;
            cnt_nxt   = cnt + CW'(1);
          end
        end
        PARITY:  state_nxt = STOP;
        STOP:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised and directed bench for fifo_uart_tx against a bit-queue line model.
module tb_fifo_uart_tx;
  localparam int DW = 8;

  logic          CLK;
  logic          RST;
  logic          EMPTY;
  logic [DW-1:0] RD_DATA;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic          R_INC;
  logic          TX_OUT;
  logic          BUSY;

  fifo_uart_tx #(.DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RST(RST), .EMPTY(EMPTY), .RD_DATA(RD_DATA),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .R_INC(R_INC), .TX_OUT(TX_OUT), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DW-1:0] fifo_q[$];
  logic          force_e = 1'b0;
  logic          mq[$];
  logic          tx_log[$];
  logic          busy_log[$];
  int            pop_log[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    EMPTY   = force_e || (fifo_q.size() == 0);
    RD_DATA = (fifo_q.size() != 0) ? fifo_q[0] : DW'($urandom);
  endtask

  task automatic push(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    drive();
  endtask

  // One clock: pop the FIFO model if R_INC was high, then log the new line state.
  task automatic step();
    logic p;
    @(negedge CLK);
    p = R_INC;
    @(posedge CLK);
    #1;
    if (p) begin
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      pop_log.push_back(tx_log.size());
    end
    tx_log.push_back(TX_OUT);
    busy_log.push_back(BUSY);
    drive();
  endtask

  task automatic log_clear();
    tx_log.delete();
    busy_log.delete();
    pop_log.delete();
  endtask

  function automatic logic [31:0] pack_tx(input int from, input int n);
    logic [31:0] v = '0;
    for (int i = 0; i < n; i++)
      if (from + i < tx_log.size()) v[i] = tx_log[from + i];
    return v;
  endfunction

  function automatic int busy_sum(input int from, input int n);
    int s = 0;
    for (int i = 0; i < n; i++)
      if (from + i < busy_log.size()) s += int'(busy_log[from + i]);
    return s;
  endfunction

  // Line model: a queue of the bits still owed on TX_OUT
  always @(negedge CLK) begin
    logic etx, ebusy, erinc;
    if (!RST) mq.delete();
    if (mq.size() > 0) begin
      etx   = mq.pop_front();
      ebusy = 1'b1;
    end else begin
      etx   = 1'b1;
      ebusy = 1'b0;
    end
    erinc = RST && (mq.size() == 0) && !EMPTY;
    chk("tx_out", 32'(TX_OUT), 32'(etx));
    chk("busy",   32'(BUSY),   32'(ebusy));
    chk("r_inc",  32'(R_INC),  32'(erinc));
    if (erinc) begin
      mq.push_back(1'b0);
      for (int i = 0; i < DW; i++) mq.push_back(RD_DATA[i]);
      if (PAR_EN) mq.push_back((^RD_DATA) ^ PAR_TYP);
      mq.push_back(1'b1);
    end
  end

  task automatic par_frame(input logic [DW-1:0] w, input logic pe, input logic pt,
                           input logic exp_par, input string nm);
    log_clear();
    PAR_EN  = pe;
    PAR_TYP = pt;
    push(w);
    repeat (13) step();
    chk({nm, "_parity_bit"}, 32'(tx_log[9]), 32'(exp_par));
    chk({nm, "_stop_idle"},  pack_tx(10, 3), 32'h7);
    chk({nm, "_busy_len"},   32'(busy_sum(0, 13)), 32'd11);
  endtask

  initial begin
    RST = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    drive();
    #12;
    chk("reset_tx",   32'(TX_OUT), 32'd1);
    chk("reset_busy", 32'(BUSY),   32'd0);
    chk("reset_rinc", 32'(R_INC),  32'd0);
    @(posedge CLK); #1; RST = 1'b1;

    // empty guard
    log_clear();
    repeat (50) step();
    chk("empty_pops",  32'(pop_log.size()), 32'd0);
    chk("empty_busy",  32'(busy_sum(0, 50)), 32'd0);
    begin
      int ones = 0;
      foreach (tx_log[i]) ones += int'(tx_log[i]);
      chk("empty_tx_high", 32'(ones), 32'd50);
    end

    // single A5, no parity
    log_clear();
    push(8'hA5);
    repeat (12) step();
    chk("a5_frame",    pack_tx(0, 12), 32'b1111_0100_1010);
    chk("a5_busy_len", 32'(busy_sum(0, 12)), 32'd10);
    chk("a5_pops",     32'(pop_log.size()), 32'd1);
    chk("a5_pop_at",   32'(pop_log[0]), 32'd0);

    par_frame(8'hA5, 1'b1, 1'b0, 1'b0, "a5_even");
    par_frame(8'hA5, 1'b1, 1'b1, 1'b1, "a5_odd");
    par_frame(8'h07, 1'b1, 1'b0, 1'b1, "x07_even");

    // back-to-back
    PAR_EN = 1'b0;
    log_clear();
    push(8'h55);
    push(8'hFF);
    repeat (22) step();
    chk("b2b_pops",    32'(pop_log.size()), 32'd2);
    chk("b2b_spacing", 32'(pop_log[1] - pop_log[0]), 32'd10);
    chk("b2b_first",   pack_tx(0, 10), 32'b1010101010);
    chk("b2b_second",  pack_tx(10, 10), 32'b1111111110);
    chk("b2b_busy",    32'(busy_sum(0, 20)), 32'd20);
    chk("b2b_idle",    32'(busy_sum(20, 2)), 32'd0);

    // PAR_EN dropped mid-frame
    log_clear();
    PAR_EN = 1'b1; PAR_TYP = 1'b0;
    push(8'h3C);
    repeat (3) step();
    PAR_EN = 1'b0;
    repeat (8) step();
    push(8'h3C);
    repeat (12) step();
    chk("cfg_parity_bit",  32'(tx_log[9]), 32'd0);
    chk("cfg_stop",        32'(tx_log[10]), 32'd1);
    chk("cfg_second_pop",  32'(pop_log[1]), 32'd11);
    chk("cfg_second_idle", 32'(busy_log[21]), 32'd0);
    chk("cfg_busy_total",  32'(busy_sum(0, 23)), 32'd21);

    // EMPTY toggling mid-frame
    log_clear();
    push(8'hA5);
    repeat (3) step();
    push(8'h5A);
    step();
    force_e = 1'b1; drive();
    repeat (2) step();
    force_e = 1'b0; drive();
    repeat (16) step();
    chk("toggle_pops",   32'(pop_log.size()), 32'd2);
    chk("toggle_pop_at", 32'(pop_log[1]), 32'd10);

    // reset mid-DATA with a word still waiting
    log_clear();
    push(8'hA5);
    push(8'h5A);
    repeat (4) step();
    #1 RST = 1'b0;
    #1;
    chk("midrst_tx",   32'(TX_OUT), 32'd1);
    chk("midrst_busy", 32'(BUSY),   32'd0);
    chk("midrst_rinc", 32'(R_INC),  32'd0);
    repeat (2) step();
    RST = 1'b1;
    log_clear();
    repeat (12) step();
    chk("postrst_pops",  32'(pop_log.size()), 32'd1);
    chk("postrst_frame", pack_tx(0, 10), 32'b1010110100);
    chk("postrst_fifo",  32'(fifo_q.size()), 32'd0);

    // randomised traffic
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 2) == 0 && fifo_q.size() < 4) fifo_q.push_back(DW'($urandom));
      if ($urandom_range(0, 6) == 0) PAR_EN = 1'($urandom);
      if ($urandom_range(0, 6) == 0) PAR_TYP = 1'($urandom);
      force_e = ($urandom_range(0, 5) == 0);
      drive();
      if (n == 300) begin
        #1 RST = 1'b0;
        step();
        RST = 1'b1;
      end
      step();
    end
    force_e = 1'b0;
    drive();
    for (int n = 0; n < 80 && (fifo_q.size() > 0 || BUSY); n++) step();
    repeat (3) step();
    chk("drain_fifo", 32'(fifo_q.size()), 32'd0);
    chk("drain_idle", 32'(BUSY), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1);
  end

endmodule
